// File: rtl/pacman_int_ctrl_pkg.sv
// Shared constants and types for the Pac-Man interrupt responder.
package pacman_io_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [15:0] INT_ENABLE_ADDR     = 16'h5000;
    localparam byte_t       INT_VECTOR_PORT     = 8'h00;
    localparam int          DEFAULT_TICK_CYCLES = 833333;

endpackage

// File: rtl/pacman_int_ctrl_if.sv
// Z80 bus view seen by the interrupt responder. The CPU side is the master;
// the controller is the slave that returns int_n and the vector byte.
interface pacman_int_ctrl_if;
    import pacman_io_pkg::*;

    logic [15:0] cpu_A;
    byte_t       cpu_dout;
    logic        cpu_m1_n;
    logic        cpu_mreq_n;
    logic        cpu_iorq_n;
    logic        cpu_wr_n;
    logic        cpu_int_n;
    byte_t       int_di;
    logic        int_di_valid;

    modport master (
        output cpu_A, cpu_dout, cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_wr_n,
        input  cpu_int_n, int_di, int_di_valid
    );

    modport slave (
        input  cpu_A, cpu_dout, cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_wr_n,
        output cpu_int_n, int_di, int_di_valid
    );

endinterface

// File: rtl/pacman_tick_timer.sv
// Free-running period timer: one-cycle tick the cycle after the counter
// reaches its last value.
module pacman_tick_timer
    import pacman_io_pkg::*;
#(
    parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int                CNT_W = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             at_last;

    assign at_last = (count == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= at_last;
            count <= at_last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pacman_int_ctrl.sv
// Pac-Man interrupt responder: enable latch at 0x5000, IM2 vector on OUT
// port 0x00, int_n held low from tick until the CPU acknowledges.
module pacman_int_ctrl
    import pacman_io_pkg::*;
#(
    parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    pacman_int_ctrl_if.slave    bus,
    output logic                int_enable,
    output logic                tick
);

    byte_t vector;
    logic  enable;
    logic  pending;
    logic  pending_next;
    logic  ack;
    logic  ack_d;
    logic  ack_rise;
    logic  enable_wr;
    logic  vector_wr;

    pacman_tick_timer #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign enable_wr = !bus.cpu_mreq_n && !bus.cpu_wr_n && (bus.cpu_A == INT_ENABLE_ADDR);
    assign vector_wr = !bus.cpu_iorq_n && !bus.cpu_wr_n && bus.cpu_m1_n
                       && (bus.cpu_A[7:0] == INT_VECTOR_PORT);
    assign ack       = !bus.cpu_m1_n && !bus.cpu_iorq_n;
    assign ack_rise  = ack && !ack_d;

    // A new tick wins over an ack clear so a back-to-back interrupt is never lost.
    always_comb begin
        pending_next = pending;
        if (enable_wr && !bus.cpu_dout[0])
            pending_next = 1'b0;
        else if (tick && enable)
            pending_next = 1'b1;
        else if (ack_rise)
            pending_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable        <= 1'b0;
            vector        <= 8'h00;
            pending       <= 1'b0;
            ack_d         <= 1'b0;
            bus.cpu_int_n <= 1'b1;
        end else begin
            if (enable_wr)
                enable <= bus.cpu_dout[0];
            if (vector_wr)
                vector <= bus.cpu_dout;
            pending       <= pending_next;
            ack_d         <= ack;
            bus.cpu_int_n <= !pending_next;
        end
    end

    // Valid is masked while reset is held so the cpu_di mux never sees a vector then.
    assign bus.int_di_valid = ack && reset_n;
    assign bus.int_di       = vector;
    assign int_enable       = enable;

endmodule

// File: tb/tb_pacman_int_ctrl.sv
// Directed bench for pacman_int_ctrl with a 16-cycle tick period.
module tb_pacman_int_ctrl;
    import pacman_io_pkg::*;

    localparam int TC = 16;

    typedef enum logic [2:0] { OP_IDLE, OP_MEMWR, OP_IOWR, OP_ACK } op_t;

    typedef struct {
        int          n;
        op_t         op;
        logic [15:0] addr;
        byte_t       dout;
        logic        e_int_n;
        logic        e_tick;
        logic        e_valid;
        byte_t       e_di;
        logic        e_en;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic int_enable;
    logic tick;
    int   n_cmp  = 0;
    int   n_fail = 0;

    pacman_int_ctrl_if bus ();

    pacman_int_ctrl #(.TICK_CYCLES(TC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .int_enable (int_enable),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive(input op_t op, input logic [15:0] addr, input byte_t dout);
        bus.cpu_A      = addr;
        bus.cpu_dout   = dout;
        bus.cpu_m1_n   = 1'b1;
        bus.cpu_mreq_n = 1'b1;
        bus.cpu_iorq_n = 1'b1;
        bus.cpu_wr_n   = 1'b1;
        case (op)
            OP_MEMWR: begin bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
            OP_IOWR:  begin bus.cpu_iorq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
            OP_ACK:   begin bus.cpu_m1_n = 1'b0; bus.cpu_iorq_n = 1'b0; end
            default:  ;
        endcase
    endtask

    task automatic check_all(input string tag, input int step, input logic e_int_n, input logic e_tick,
                             input logic e_valid, input byte_t e_di, input logic e_en);
        check({tag, ".int_n"}, step, {7'b0, bus.cpu_int_n},    {7'b0, e_int_n});
        check({tag, ".tick"},  step, {7'b0, tick},             {7'b0, e_tick});
        check({tag, ".valid"}, step, {7'b0, bus.int_di_valid}, {7'b0, e_valid});
        check({tag, ".di"},    step, bus.int_di,               e_di);
        check({tag, ".en"},    step, {7'b0, int_enable},       {7'b0, e_en});
    endtask

    vec_t vecs[$];
    int   step;

    initial begin
        // Step k = k-th rising edge after reset release; results sampled 1ns later.
        vecs = '{
            '{1,  OP_IOWR,  16'hAB00, 8'hCF, 1, 0, 0, 8'hCF, 0},  // vector, upper addr ignored
            '{1,  OP_MEMWR, 16'h5000, 8'h01, 1, 0, 0, 8'hCF, 1},  // enable
            '{1,  OP_MEMWR, 16'h5001, 8'h00, 1, 0, 0, 8'hCF, 1},  // wrong address
            '{1,  OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hCF, 1},
            '{1,  OP_IOWR,  16'h0001, 8'h55, 1, 0, 0, 8'hCF, 1},  // wrong port
            '{10, OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hCF, 1},  // 6..15
            '{1,  OP_IDLE,  16'h0000, 8'h00, 1, 1, 0, 8'hCF, 1},  // 16 tick
            '{1,  OP_IDLE,  16'h0000, 8'h00, 0, 0, 0, 8'hCF, 1},  // 17 int_n low
            '{1,  OP_ACK,   16'h0000, 8'h00, 1, 0, 1, 8'hCF, 1},  // 18 ack edge
            '{2,  OP_ACK,   16'h0000, 8'h00, 1, 0, 1, 8'hCF, 1},  // 19..20
            '{11, OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hCF, 1},  // 21..31
            '{1,  OP_MEMWR, 16'h5000, 8'h00, 1, 1, 0, 8'hCF, 0},  // 32 disable, tick
            '{15, OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hCF, 0},  // 33..47
            '{1,  OP_IDLE,  16'h0000, 8'h00, 1, 1, 0, 8'hCF, 0},  // 48
            '{15, OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hCF, 0},  // 49..63
            '{1,  OP_IDLE,  16'h0000, 8'h00, 1, 1, 0, 8'hCF, 0},  // 64
            '{1,  OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hCF, 0},  // 65
            '{1,  OP_MEMWR, 16'h5000, 8'h01, 1, 0, 0, 8'hCF, 1},  // 66 enable between ticks
            '{13, OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hCF, 1},  // 67..79
            '{1,  OP_IDLE,  16'h0000, 8'h00, 1, 1, 0, 8'hCF, 1},  // 80
            '{1,  OP_IDLE,  16'h0000, 8'h00, 0, 0, 0, 8'hCF, 1},  // 81
            '{1,  OP_MEMWR, 16'h5000, 8'h00, 1, 0, 0, 8'hCF, 0},  // 82 disable clears
            '{1,  OP_MEMWR, 16'h5000, 8'h01, 1, 0, 0, 8'hCF, 1},  // 83
            '{12, OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hCF, 1},  // 84..95
            '{1,  OP_IDLE,  16'h0000, 8'h00, 1, 1, 0, 8'hCF, 1},  // 96
            '{1,  OP_IDLE,  16'h0000, 8'h00, 0, 0, 0, 8'hCF, 1},  // 97
            '{1,  OP_IOWR,  16'h0000, 8'hE7, 0, 0, 0, 8'hE7, 1},  // 98 vector while pending
            '{13, OP_IDLE,  16'h0000, 8'h00, 0, 0, 0, 8'hE7, 1},  // 99..111
            '{1,  OP_IDLE,  16'h0000, 8'h00, 0, 1, 0, 8'hE7, 1},  // 112
            '{1,  OP_ACK,   16'h0000, 8'h00, 0, 0, 1, 8'hE7, 1},  // 113 ack edge + tick
            '{1,  OP_ACK,   16'h0000, 8'h00, 0, 0, 1, 8'hE7, 1},  // 114
            '{1,  OP_IDLE,  16'h0000, 8'h00, 0, 0, 0, 8'hE7, 1},  // 115
            '{1,  OP_ACK,   16'h0000, 8'h00, 1, 0, 1, 8'hE7, 1},  // 116 second ack
            '{1,  OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hE7, 1},  // 117
            '{10, OP_IDLE,  16'h0000, 8'h00, 1, 0, 0, 8'hE7, 1},  // 118..127
            '{1,  OP_IDLE,  16'h0000, 8'h00, 1, 1, 0, 8'hE7, 1},  // 128
            '{1,  OP_IDLE,  16'h0000, 8'h00, 0, 0, 0, 8'hE7, 1}   // 129 pending
        };

        drive(OP_IDLE, 16'h0000, 8'h00);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 1, 0, 0, 8'h00, 0);

        reset_n = 1'b1;
        step = 0;
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].n; r++) begin
                drive(vecs[i].op, vecs[i].addr, vecs[i].dout);
                @(posedge clk);
                #1;
                step++;
                check_all("vec", step, vecs[i].e_int_n, vecs[i].e_tick, vecs[i].e_valid,
                          vecs[i].e_di, vecs[i].e_en);
            end
        end

        // Reset while acknowledging with an interrupt pending.
        drive(OP_ACK, 16'h0000, 8'h00);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_ack", 0, 1, 0, 0, 8'h00, 0);

        reset_n = 1'b1;
        drive(OP_IDLE, 16'h0000, 8'h00);
        @(posedge clk);
        #1;
        check_all("post_rst", 1, 1, 0, 0, 8'h00, 0);
        drive(OP_ACK, 16'h0000, 8'h00);
        @(posedge clk);
        #1;
        check_all("post_rst_ack", 2, 1, 0, 1, 8'h00, 0);

        // Timer restarted from zero: tick lands on the 16th edge after release.
        drive(OP_IDLE, 16'h0000, 8'h00);
        for (int k = 3; k <= TC + 1; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_tick", k, {7'b0, tick}, {7'b0, (k == TC)});
            check("post_rst_int_n", k, {7'b0, bus.cpu_int_n}, 8'h01);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pacman_int_ctrl.md
Name: pacman_int_ctrl

Overview:
Z80 interrupt responder for the Pac-Man system. It replaces the free-running interrupt hack in the system top with Pac-Man-accurate behaviour:
- periodic tick timer;
- interrupt-enable latch at 0x5000;
- IM2 vector latch written via OUT to port 0x00;
- holds int_n low until the CPU acknowledges, then drives the vector byte onto the CPU data-in mux.

It sits between the tv80s bus outputs and the cpu_di mux in the system top.

Parameters:
TICK_CYCLES, 833333, clk cycles per interrupt tick (60 Hz at 50 MHz); must be >= 2
CNT_W, $clog2(TICK_CYCLES), tick counter width (derived, not overridden)

Ports:
clk  in  1  system clock, single domain
reset_n  in  1  synchronous active-low reset
cpu_A  in  16  CPU address bus
cpu_dout  in  8  CPU data out
cpu_m1_n  in  1  CPU machine cycle one
cpu_mreq_n  in  1  CPU memory request
cpu_iorq_n  in  1  CPU IO request
cpu_wr_n  in  1  CPU write strobe
cpu_int_n  out  1  interrupt request to CPU, active low, registered
int_di  out  8  vector byte for cpu_di mux
int_di_valid  out  1  high during interrupt acknowledge; highest priority in the cpu_di mux
int_enable  out  1  current enable latch value (status)
tick  out  1  one-cycle pulse each timer period, for GPU/sound use

Behaviour:
- Reset (reset_n=0 at posedge clk), synchronous, overrides everything, including mid-acknowledge:
  - counter=0, enable=0, vector=8'h00, pending=0, ack_d=0;
  - outputs: cpu_int_n=1, tick=0, int_enable=0, int_di=8'h00, int_di_valid=0.
- Timer:
  - counter counts 0..TICK_CYCLES-1, then wraps to 0;
  - tick is registered high for exactly one cycle, the cycle after counter==TICK_CYCLES-1;
  - first tick comes TICK_CYCLES cycles after reset release;
  - runs regardless of enable.
- Enable write:
  - condition: cpu_mreq_n=0 & cpu_wr_n=0 & cpu_A==16'h5000, sampled every cycle (level; repeated cycles are idempotent);
  - enable <= cpu_dout[0];
  - writing 0 also clears pending.
- Vector write:
  - condition: cpu_iorq_n=0 & cpu_wr_n=0 & cpu_m1_n=1 & cpu_A[7:0]==8'h00;
  - vector <= cpu_dout; upper address byte ignored.
- Ack condition: ack = cpu_m1_n=0 & cpu_iorq_n=0.
  - int_di_valid = ack (combinational); int_di = vector (registered value).
  - ack_d <= ack; the ack rising edge (ack & ~ack_d) clears pending.
- Pending next-state, priority high to low:
  1. reset: 0
  2. enable write with dout[0]=0: 0
  3. tick & enable: 1 (set beats ack clear in the same cycle)
  4. ack rising edge: 0
  5. otherwise: hold
- A tick while enable=0 is dropped, not remembered.
- cpu_int_n <= ~pending_next, so int_n falls one cycle after the tick pulse is generated and rises the cycle after the ack edge.
- int_enable mirrors the enable register.
- Vector write and ack cannot coincide (m1_n differs). A vector write while pending is legal; the new vector is used at ack.

Decomposition:
- Package pacman_io_pkg holds:
  - INT_ENABLE_ADDR = 16'h5000
  - INT_VECTOR_PORT = 8'h00
  - DEFAULT_TICK_CYCLES = 833333
  - typedef logic [7:0] byte_t
- One sub-module, pacman_tick_timer (parameter TICK_CYCLES; ports clk, reset_n, tick), containing the counter and pulse.
- Decode, latches, pending and ack logic stay in pacman_int_ctrl.

Test Plan:
(All scenarios use TICK_CYCLES=16.)
- Reset: hold reset_n=0 for 3 cycles -> cpu_int_n=1, tick=0, int_di_valid=0, int_enable=0, int_di=8'h00. After release, first tick pulse 16 cycles later, then every 16 cycles.
- Vector/enable/ack:
  - stimulus: OUT 0x00 with 8'hCF; mem write 0x5000 with 8'h01;
  - at next tick -> cpu_int_n=0 one cycle later;
  - assert m1_n=0, iorq_n=0 for 3 cycles -> int_di_valid=1 and int_di=8'hCF for all 3, cpu_int_n=1 the cycle after the first ack cycle.
- Disabled: enable=0 across 3 ticks -> cpu_int_n stays 1. Set enable=1 between ticks -> no interrupt until the next tick (dropped ticks not replayed).
- Disable clears: pending with cpu_int_n=0, then write 8'h00 to 0x5000 -> cpu_int_n=1 next cycle, int_enable=0.
- Tick during ack: align the ack rising edge with the tick cycle -> pending stays 1 and cpu_int_n remains 0 after the ack. A second ack (rising edge) clears it.
- Reset mid-ack: reset_n=0 while ack is active and pending=1 -> all outputs return to reset values next cycle; vector reads back 8'h00 on the next ack.
